fp_smul_iter: RTL and testbench
===============================

# fp_sMul_iter

Iterative signed fixed-point multiplier that sits on the output side of the reciprocal unit.
- Takes an operand `a` (WI.WF) and the reciprocal result `b` (WIO.WFO) and returns `a*b` in WIP.WFP format, completing division `a/x = a*(1/x)`.
- Also serves as the self-check path: `x*(1/x)≈1`.
- Radix-2 shift-add, one bit of `|b|` per cycle, valid/ready on both sides, round-half-away-from-zero, saturating output.

## Interface
Parameters:
- `WI`, 4: integer bits of `a`, including sign.
- `WF`, 4: fractional bits of `a`.
- `WIO`, 4: integer bits of `b`, including sign.
- `WFO`, 4: fractional bits of `b`.
- `WIP`, 4: integer bits of product, including sign.
- `WFP`, 4: fractional bits of product.

Derived (localparams): WLA=WI+WF, WLB=WIO+WFO, WLP=WIP+WFP. Required: WF+WFO ≥ WFP+1.

Ports:
- `CLK` in 1: clock, rising edge. One clock; reset is asynchronous and active-high.
- `RST` in 1: asynchronous, active-high reset.
- `CE` in 1: clock enable; when low, all state holds.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `a` in WLA: signed multiplicand.
- `b` in WLB: signed multiplier (reciprocal result).
- `out_valid` out 1: product valid.
- `out_ready` in 1: consumer accepts the product.
- `p` out WLP: signed saturated product.
- `sat` out 1: saturation occurred on this product; qualified by `out_valid`.

## Operation
- Reset (async, any state) values: state=IDLE, in_ready=1, out_valid=0, p=0, sat=0, all internal registers 0. An in-flight operation is discarded.
- States and transitions:
  - IDLE → MUL on accept, which is `CE & in_valid & in_ready`.
  - MUL → FIN after WLB iterations.
  - FIN → HOLD.
  - HOLD → IDLE when `CE & out_ready`.
- `in_ready` is 1 only in IDLE.
- Accept:
  - Latch sign `s = a[WLA-1]^b[WLB-1]`.
  - Latch magnitudes `|a|` (WLA bits, unsigned) and `|b|` (WLB bits, unsigned). `|−2^(n-1)|` = 2^(n-1) fits without overflow.
  - Clear accumulator (WLA+WLB bits) and iteration counter.
- MUL, per cycle: if the LSB of the `|b|` shift register is 1, add `|a|<<k` into the accumulator; shift `|b|` right; increment k. Exit when k = WLB-1 completes.
- FIN:
  - Round: magnitude `m = (acc + 2^(D-1)) >> D`, where D = WF+WFO−WFP.
  - Saturate: if s=0 and m > 2^(WLP-1)−1, then p = 2^(WLP-1)−1 and sat=1. If s=1 and m > 2^(WLP-1), then p = −2^(WLP-1) and sat=1. Otherwise p = s ? −m : m and sat=0.
  - A result of −0 is output as 0.
  - Register p and sat; set out_valid at the end of FIN.
- HOLD: `p`, `sat` and `out_valid` are stable until the handshake. On `out_ready` (with CE), out_valid clears on the next edge. `p` keeps its last value until the next FIN.
- `CE`=0 in any state: no transition, no counter or accumulator change. Handshakes only complete when CE=1.

## Timing
- Latency: with accept on edge N, out_valid=1 after edge N+WLB+2 (10 edges at defaults).
- Throughput: one result per WLB+4 cycles. No accept in the same cycle a result is drained; IDLE is always visited.
- `in_valid` while busy is ignored. The upstream source must hold `a`/`b` until `in_ready`.
- `out_ready` asserted before `out_valid` has no effect.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `fp_pkg`: state encoding (IDLE/MUL/FIN/HOLD), and the magnitude, rounding-offset and saturation-limit helper functions, reusable by fp_sRec variants.
- One natural sub-module: `fp_sat_round`, the combinational round + saturate + sign-apply stage used in FIN.
- The counter and datapath are in the top level.

## Test plan
All values below use default parameters (4.4 formats).
- a=0001_1000 (1.5), b=0000_1011 (0.6875) → p=0001_0001 (1.0625, rounded from 1.03125), sat=0; out_valid exactly 10 edges after accept.
- a=1110_1000 (−1.5), b=0000_1011 → p=1110_1111, sat=0 (symmetric rounding).
- a=0111_1111, b=0111_1111 → p=0111_1111, sat=1. a=1000_0000, b=1000_0000 → p=0111_1111, sat=1.
- a=1000_0000, b=0001_0000 → p=1000_0000, sat=0. a=1000_0000, b=0010_0000 → p=1000_0000, sat=1. a=0, b=1000_0000 → p=0, sat=0.
- Handshake:
  - Hold out_ready=0 for 5 cycles → p stable and in_ready=0 throughout.
  - Toggle CE low for 3 cycles mid-MUL → latency extends by exactly 3.
  - Assert in_valid while busy → input ignored.
- Assert RST mid-MUL → in_ready=1, out_valid=0 and p=0 immediately (async). The next operation (1.5×0.6875) returns 0001_0001.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared definitions for the fixed-point arithmetic blocks
//            (iterative multiplier, reciprocal variants).
//            - fp_state_e : IDLE / MUL / FIN / HOLD sequencing states
//            - fp_mag     : unsigned magnitude of an n-bit two's-complement word
//            - fp_round_ofs : half-LSB offset for dropping d fractional bits
//            - fp_sat_lim : largest magnitude representable in n signed bits
//            All helpers work on a 64-bit carrier word; callers slice out
//            the width they need.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  localparam int FP_MAXW = 64;

  typedef logic [FP_MAXW-1:0] fp_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2,
    ST_HOLD = 2'd3
  } fp_state_e;

  // Magnitude of the low n bits of v read as a signed number. The most
  // negative value maps to 2^(n-1), which still fits in n unsigned bits.
  function automatic fp_word_t fp_mag(input fp_word_t v, input int n);
    fp_word_t mask;
    fp_word_t sgn;
    mask = (n >= FP_MAXW) ? '1 : ((fp_word_t'(1) << n) - fp_word_t'(1));
    sgn  = v >> (n - 1);
    if (sgn[0]) begin
      return (~v + fp_word_t'(1)) & mask;
    end
    return v & mask;
  endfunction

  // Adding half an output LSB before truncation gives round-half-away-from-
  // zero, because the rounding is applied to the magnitude, not the signed value.
  function automatic fp_word_t fp_round_ofs(input int d);
    return (d <= 0) ? '0 : (fp_word_t'(1) << (d - 1));
  endfunction

  // Largest magnitude allowed for an n-bit signed result: 2^(n-1)-1 for a
  // positive result, 2^(n-1) for a negative one.
  function automatic fp_word_t fp_sat_lim(input int n, input logic neg);
    fp_word_t lim;
    lim = fp_word_t'(1) << (n - 1);
    return neg ? lim : (lim - fp_word_t'(1));
  endfunction

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_sat_round.sv
`default_nettype none
// ============================================================================
// Module   : fp_sat_round
// Purpose  : Combinational round + saturate + sign-apply stage. Takes an
//            unsigned product magnitude and the product sign, drops D
//            fractional bits with round-half-away-from-zero, clamps to the
//            WLP-bit signed range and applies the sign.
// Ports    : acc [WACC] in  - unsigned product magnitude
//            neg        in  - product sign (1 = negative)
//            p   [WLP]  out - signed, rounded, saturated result
//            sat        out - clamping was applied
// Revision : 1.0 - initial release
// ============================================================================
module fp_sat_round
  import fp_pkg::*;
#(
  parameter int WACC = 16,
  parameter int D    = 4,
  parameter int WLP  = 8
) (
  input  logic [WACC-1:0] acc,
  input  logic            neg,
  output logic [WLP-1:0]  p,
  output logic            sat
);

  fp_word_t acc_w;
  fp_word_t m;
  fp_word_t lim_pos;
  fp_word_t lim_neg;
  fp_word_t p_w;
  logic     unused_p_hi;

  always_comb begin
    acc_w              = '0;
    acc_w[WACC-1:0]    = acc;
    m                  = (acc_w + fp_round_ofs(D)) >> D;
    lim_pos            = fp_sat_lim(WLP, 1'b0);
    lim_neg            = fp_sat_lim(WLP, 1'b1);
    sat                = 1'b0;
    p_w                = '0;
    if (!neg && (m > lim_pos)) begin
      p_w = lim_pos;
      sat = 1'b1;
    end else if (neg && (m > lim_neg)) begin
      p_w = ~lim_neg + fp_word_t'(1);
      sat = 1'b1;
    end else if (neg) begin
      // A zero magnitude negates to zero, so -0 never reaches the output.
      p_w = ~m + fp_word_t'(1);
    end else begin
      p_w = m;
    end
    p = p_w[WLP-1:0];
  end

  assign unused_p_hi = ^p_w[FP_MAXW-1:WLP];

endmodule : fp_sat_round
`default_nettype wire

// File: rtl/fp_smul_iter.sv
`default_nettype none
// ============================================================================
// Module   : fp_smul_iter
// Purpose  : Iterative signed fixed-point multiplier, p = a * b.
//            Radix-2 shift-add on |b|, one bit per cycle, with a valid/ready
//            handshake on both sides, round-half-away-from-zero and a
//            saturating output. Sequence: IDLE -> MUL (WLB cycles) ->
//            FIN (2 cycles) -> HOLD -> IDLE.
// Ports    : CLK                 in  - clock, rising edge
//            RST                 in  - asynchronous active-high reset
//            CE                  in  - clock enable, low freezes all state
//            in_valid / in_ready     - operand handshake
//            a  [WI+WF]          in  - signed multiplicand
//            b  [WIO+WFO]        in  - signed multiplier
//            out_valid / out_ready   - result handshake
//            p  [WIP+WFP]        out - signed saturated product
//            sat                 out - saturation flag, qualified by out_valid
// Revision : 1.0 - initial release
// ============================================================================
module fp_smul_iter
  import fp_pkg::*;
#(
  parameter int WI  = 4,
  parameter int WF  = 4,
  parameter int WIO = 4,
  parameter int WFO = 4,
  parameter int WIP = 4,
  parameter int WFP = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI+WF-1:0]     a,
  input  logic [WIO+WFO-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIP+WFP-1:0]   p,
  output logic                 sat
);

  localparam int WLA  = WI + WF;
  localparam int WLB  = WIO + WFO;
  localparam int WLP  = WIP + WFP;
  localparam int WACC = WLA + WLB;
  localparam int DSH  = WF + WFO - WFP;
  localparam int KW   = (WLB > 1) ? $clog2(WLB) : 1;

  fp_state_e         state_q,     state_d;
  logic [WLA-1:0]    a_mag_q,     a_mag_d;
  logic [WLB-1:0]    b_sh_q,      b_sh_d;
  logic [WACC-1:0]   acc_q,       acc_d;
  logic [KW-1:0]     k_q,         k_d;
  logic              s_q,         s_d;
  logic              fin_ph_q,    fin_ph_d;
  logic [WLP-1:0]    p_stage_q,   p_stage_d;
  logic              sat_stage_q, sat_stage_d;
  logic [WLP-1:0]    p_q,         p_d;
  logic              sat_q,       sat_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q,  in_ready_d;

  fp_word_t          a_w;
  fp_word_t          b_w;
  logic              unused_mag_hi;
  logic [WLP-1:0]    rnd_p;
  logic              rnd_sat;

  assign a_w = fp_mag({{(FP_MAXW-WLA){1'b0}}, a}, WLA);
  assign b_w = fp_mag({{(FP_MAXW-WLB){1'b0}}, b}, WLB);
  assign unused_mag_hi = ^{a_w[FP_MAXW-1:WLA], b_w[FP_MAXW-1:WLB]};

  fp_sat_round #(
    .WACC (WACC),
    .D    (DSH),
    .WLP  (WLP)
  ) u_sat_round (
    .acc  (acc_q),
    .neg  (s_q),
    .p    (rnd_p),
    .sat  (rnd_sat)
  );

  always_comb begin
    state_d     = state_q;
    a_mag_d     = a_mag_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    k_d         = k_q;
    s_d         = s_q;
    fin_ph_d    = fin_ph_q;
    p_stage_d   = p_stage_q;
    sat_stage_d = sat_stage_q;
    p_d         = p_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    if (CE) begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = ST_MUL;
            s_d     = a[WLA-1] ^ b[WLB-1];
            a_mag_d = a_w[WLA-1:0];
            b_sh_d  = b_w[WLB-1:0];
            acc_d   = '0;
            k_d     = '0;
          end
        end
        ST_MUL: begin
          if (b_sh_q[0]) begin
            acc_d = acc_q + ({{WLB{1'b0}}, a_mag_q} << k_q);
          end
          b_sh_d = b_sh_q >> 1;
          if (k_q == KW'(WLB - 1)) begin
            k_d     = '0;
            state_d = ST_FIN;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        ST_FIN: begin
          // First FIN cycle registers the round/saturate result so that
          // adder and comparators get a full cycle from a stable accumulator;
          // the second cycle publishes it.
          if (!fin_ph_q) begin
            p_stage_d   = rnd_p;
            sat_stage_d = rnd_sat;
            fin_ph_d    = 1'b1;
          end else begin
            p_d         = p_stage_q;
            sat_d       = sat_stage_q;
            out_valid_d = 1'b1;
            fin_ph_d    = 1'b0;
            state_d     = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      a_mag_q     <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      s_q         <= 1'b0;
      fin_ph_q    <= 1'b0;
      p_stage_q   <= '0;
      sat_stage_q <= 1'b0;
      p_q         <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_mag_q     <= a_mag_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      s_q         <= s_d;
      fin_ph_q    <= fin_ph_d;
      p_stage_q   <= p_stage_d;
      sat_stage_q <= sat_stage_d;
      p_q         <= p_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign sat       = sat_q;

endmodule : fp_smul_iter
`default_nettype wire

// File: tb/tb_fp_smul_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_smul_iter
// Purpose  : Self-checking bench for fp_smul_iter at default 4.4 formats.
//            Directed corner products, handshake/CE/reset scenarios and
//            randomized operands compared against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_smul_iter;

  localparam int D       = 4;   // WF + WFO - WFP
  localparam int LAT_NOM = 10;  // WLB + 2

  logic       clk;
  logic       rst;
  logic       ce;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] p;
  logic       sat;

  int n_vec;
  int n_err;

  fp_smul_iter #(
    .WI(4), .WF(4), .WIO(4), .WFO(4), .WIP(4), .WFP(4)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .CE        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Exact signed product, then round the magnitude half-away-from-zero and
  // clamp to the 8-bit signed range.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                       output logic [7:0] ep, output logic es);
    longint prod;
    longint mag;
    longint m;
    bit     neg;
    prod = longint'($signed(ma)) * longint'($signed(mb));
    neg  = (prod < 0);
    mag  = neg ? -prod : prod;
    m    = (mag + (longint'(1) << (D - 1))) >> D;
    es   = 1'b0;
    if (!neg && m > 127) begin
      ep = 8'h7F; es = 1'b1;
    end else if (neg && m > 128) begin
      ep = 8'h80; es = 1'b1;
    end else begin
      ep = 8'(neg ? -m : m);
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
  endtask

  task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b,
                       input int ce_at, input int ce_len,
                       input int hold, input bit spam);
    int         lat;
    logic [7:0] ep;
    logic       es;
    logic [7:0] p0;
    model(op_a, op_b, ep, es);
    wait_ready();
    a = op_a; b = op_b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = spam;
    if (spam) begin
      a = 8'($urandom); b = 8'($urandom);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      ce = !(lat >= ce_at && lat < ce_at + ce_len);
      @(posedge clk); #1;
      lat++;
    end
    ce = 1'b1;
    in_valid = 1'b0;
    chk("latency", lat, LAT_NOM + ce_len);
    chk("in_ready_busy", in_ready, 0);
    chk("p", p, ep);
    chk("sat", sat, es);
    p0 = p;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_p", p, p0);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_p_kept", p, ep);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] da [7];
    logic [7:0] db [7];
    n_vec = 0; n_err = 0;
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_sat", sat, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    da = '{8'h18, 8'hE8, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h00};
    db = '{8'h0B, 8'h0B, 8'h7F, 8'h80, 8'h10, 8'h20, 8'h80};
    do_op(da[0], db[0], 0, 0, 5, 1'b0);
    for (int i = 1; i < 7; i++) do_op(da[i], db[i], 0, 0, 0, 1'b0);

    // CE gap of three cycles inside MUL, with in_valid spam while busy.
    do_op(8'h18, 8'h0B, 3, 3, 1, 1'b1);

    // Asynchronous reset in the middle of MUL, while p still shows 0x11.
    do_op(8'h18, 8'h0B, 0, 0, 0, 1'b0);
    wait_ready();
    a = 8'h7F; b = 8'h7F; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_p", p, 0);
    chk("arst_sat", sat, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    do_op(8'h18, 8'h0B, 0, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom), 8'($urandom),
            int'($urandom_range(1, 5)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fp_smul_iter
`default_nettype wire
